// File: rtl/div_if.sv
// Start/busy/done handshake between the EX stage and the iterative divider.
interface div_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  modport master (output start, is_signed, A, B, cancel,
                  input  busy, done, quot, rem);
  modport slave  (input  start, is_signed, A, B, cancel,
                  output busy, done, quot, rem);
endinterface

// File: rtl/iter_div.sv
// Restoring integer divider, one quotient bit per cycle, signed/unsigned,
// with cancel for pipeline flush. Divide-by-zero returns all ones / dividend.
module iter_div #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] pr;      // partial remainder
  logic [WIDTH-1:0] qr;      // dividend shifting out / quotient shifting in
  logic [WIDTH-1:0] absb;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r;
  logic             busy_r, done_r;
  logic [WIDTH-1:0] quot_r, rem_r;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   sh, trial;

  always_comb begin
    abs_a = (bus.is_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    abs_b = (bus.is_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    sh    = {pr, qr[WIDTH-1]};
    trial = sh - {1'b0, absb};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pr     <= '0;
      qr     <= '0;
      absb   <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      quot_r <= '0;
      rem_r  <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            busy_r <= 1'b1;
            if (bus.B == '0) begin
              // Raw results, no sign fix-up, straight to FIN.
              pr    <= bus.A;
              qr    <= '1;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_FIN;
            end else begin
              pr    <= '0;
              qr    <= abs_a;
              absb  <= abs_b;
              cnt   <= CW'(WIDTH);
              neg_q <= bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
              neg_r <= bus.is_signed & bus.A[WIDTH-1];
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.cancel) begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end else begin
            // pr < |B| holds every step, so a non-negative trial fits WIDTH bits.
            if (!trial[WIDTH]) begin
              pr <= trial[WIDTH-1:0];
              qr <= {qr[WIDTH-2:0], 1'b1};
            end else begin
              pr <= sh[WIDTH-1:0];
              qr <= {qr[WIDTH-2:0], 1'b0};
            end
            cnt <= cnt - 1'b1;
            if (cnt == CW'(1)) state <= S_FIN;
          end
        end
        S_FIN: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
          if (!bus.cancel) begin
            quot_r <= neg_q ? -qr : qr;
            rem_r  <= neg_r ? -pr : pr;
            done_r <= 1'b1;
          end
        end
        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.quot = quot_r;
  assign bus.rem  = rem_r;
endmodule
